spi_master_arbiter: RTL and testbench
=====================================

// Module: spi_master_arbiter
// PURPOSE
//   Shares one spi_master instance between N_REQ requesters. Each requester asks for a
//   single write or read transaction. The block picks a requester by round-robin, buffers
//   its word and issues spi_wr_cmd/spi_rd_cmd to the master. It then tracks spi_busy to
//   completion and returns miso_data to the requester with a one-cycle done pulse.
//   It sits between the host-side register/control logic and spi_master.
// PARAMETERS
//   N_REQ            4    number of requesters, 2..16
//   MOSI_DATA_WIDTH  8    write word width; must match the spi_master instance
//   MISO_DATA_WIDTH  8    read word width; must match the spi_master instance
//   BUSY_TIMEOUT     255  max clk cycles to wait for spi_busy to rise after a cmd, >=4
// PORTS
//   clk          in   1                      system clock, same clk as spi_master
//   rst          in   1                      synchronous reset, active-high
//   req          in   N_REQ                  level request per requester; held until its done
//   req_rd_nwr   in   N_REQ                  per requester: 1 = read transaction, 0 = write
//   req_data     in   N_REQ*MOSI_DATA_WIDTH  per-requester write word, slice i = requester i
//   gnt          out  N_REQ                  one-hot: requester currently owning the master
//   done         out  1                      1-cycle pulse, transaction finished
//   done_id      out  $clog2(N_REQ)          index of the finished requester, valid with done
//   done_err     out  1                      with done: busy timeout, rdata forced to 0
//   rdata        out  MISO_DATA_WIDTH        read word, valid with done (0 for writes)
//   spi_wr_cmd   out  1                      to spi_master
//   spi_rd_cmd   out  1                      to spi_master
//   mosi_data    out  MOSI_DATA_WIDTH        to spi_master, stable from ISSUE until DONE
//   spi_busy     in   1                      from spi_master
//   miso_data    in   MISO_DATA_WIDTH        from spi_master
// BEHAVIOUR
//   Reset: all outputs are 0, FSM goes to IDLE, and the round-robin pointer is set to 0.
//   Reset mid-transaction drops the cmds immediately and gives no done. The master is reset
//   by the same system.
//   FSM states: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> DONE -> IDLE.
//   IDLE: if any req bit is set, grant the first set bit found at or after ptr, wrapping
//     modulo N_REQ. Register gnt, the direction, mosi_data and the id. Go to ISSUE on the
//     next cycle. With no req, stay in IDLE.
//   ISSUE: assert spi_rd_cmd if dir=1, else spi_wr_cmd. Never assert both. Load the timeout
//     counter with BUSY_TIMEOUT. Go to WAIT_BUSY.
//   WAIT_BUSY: keep the cmd high and decrement the counter each cycle.
//     On spi_busy=1: drop the cmd and go to WAIT_DONE.
//     On counter==0 while busy is still 0: drop the cmd, set err=1, go to DONE.
//   WAIT_DONE: wait for spi_busy=0. No timeout here; the transaction length is bounded by
//     the master. When busy is 0, capture miso_data into rdata for reads (0 for writes)
//     and go to DONE.
//   DONE: done=1, done_id=id, done_err=err for exactly one cycle. gnt is cleared and
//     ptr becomes id+1 modulo N_REQ. Return to IDLE.
//   Cmd spacing: the cmd is low for at least DONE+IDLE (2 cycles) between transactions,
//     so the master sees a clean rising edge.
//   Latency: req to the cmd rising edge is 2 clk cycles (IDLE sample, then ISSUE).
//   Fairness: the requester just served has the lowest priority next time. N_REQ requesters
//     all held active are served in strict rotation.
//   The granted requester's data, direction and req are sampled only in IDLE. Later changes
//     to its inputs, and new reqs, do not affect the transaction in flight.
//   If a requester drops req before its done, the transaction still completes and done is
//     still pulsed.
//   A requester that keeps req high in the cycle after its done is treated as a new request.
//   rdata holds its value until the next done.
// TESTING
//   1. Single write: req=4'b0010, req_rd_nwr=0, data1=8'hA5. Expect spi_wr_cmd 2 cycles
//      later and mosi_data=8'hA5. Model busy for 20 cycles. Expect done with done_id=1,
//      done_err=0, rdata=0.
//   2. Single read: req=4'b0001, rd=1. Model returns miso_data=8'h3C. Expect done_id=0,
//      rdata=8'h3C, and spi_wr_cmd never asserted.
//   3. Round-robin: req=4'b1111 held. Expect done_id order 0,1,2,3,0. Also req=4'b1001
//      with ptr=1: expect 3 first, then 0.
//   4. Timeout: busy tied to 0. Expect the cmd held for BUSY_TIMEOUT cycles, then done with
//      done_err=1 and rdata=0. The next request proceeds normally.
//   5. Back-to-back: the same requester re-requests immediately. Expect the cmd low for >=2
//      cycles between transactions and two distinct spi_busy periods.
//   6. Reset in WAIT_DONE: expect cmds, gnt and done at 0 the next cycle, FSM in IDLE,
//      ptr=0, and no done pulse.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master between N_REQ requesters.
// Each grant issues one write or read command, tracks spi_busy to completion and returns the read word with a done pulse.
module spi_master_arbiter #(
  parameter int N_REQ           = 4,
  parameter int MOSI_DATA_WIDTH = 8,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int BUSY_TIMEOUT    = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req,
  input  logic [N_REQ-1:0]                   req_rd_nwr,
  input  logic [N_REQ*MOSI_DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                   gnt,
  output logic                               done,
  output logic [$clog2(N_REQ)-1:0]           done_id,
  output logic                               done_err,
  output logic [MISO_DATA_WIDTH-1:0]         rdata,
  output logic                               spi_wr_cmd,
  output logic                               spi_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]         mosi_data,
  input  logic                               spi_busy,
  input  logic [MISO_DATA_WIDTH-1:0]         miso_data
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic           dir_q;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] pick;

  // First set request at or after p, wrapping modulo N_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   p);
    logic           found;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] ii;
    int unsigned    idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(p) + k) % 32'(N_REQ);
      ii  = IDW'(idx);
      if (!found && r[ii]) begin
        found = 1'b1;
        sel   = ii;
      end
    end
    return sel;
  endfunction

  always_comb pick = rr_pick(req, ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      id_q       <= '0;
      dir_q      <= 1'b0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= 1'b0;
      done_id    <= '0;
      done_err   <= 1'b0;
      rdata      <= '0;
      spi_wr_cmd <= 1'b0;
      spi_rd_cmd <= 1'b0;
      mosi_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt       <= N_REQ'(1) << pick;
            id_q      <= pick;
            dir_q     <= req_rd_nwr[pick];
            mosi_data <= req_data[pick*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          spi_rd_cmd <= dir_q;
          spi_wr_cmd <= ~dir_q;
          cnt        <= CW'(BUSY_TIMEOUT);
          state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          cnt <= cnt - 1'b1;
          if (spi_busy) begin
            spi_rd_cmd <= 1'b0;
            spi_wr_cmd <= 1'b0;
            state      <= S_WAIT_DONE;
          end else if (cnt == CW'(1)) begin
            // Expires on the decrement to zero so the cmd stays high exactly BUSY_TIMEOUT cycles.
            spi_rd_cmd <= 1'b0;
            spi_wr_cmd <= 1'b0;
            done       <= 1'b1;
            done_id    <= id_q;
            done_err   <= 1'b1;
            rdata      <= '0;
            gnt        <= '0;
            ptr        <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            state      <= S_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            done     <= 1'b1;
            done_id  <= id_q;
            done_err <= 1'b0;
            rdata    <= dir_q ? miso_data : '0;
            gnt      <= '0;
            ptr      <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          done_err <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural spi_master model.
// Table of transactions plus hand-written timeout, back-to-back and reset sequences.
module tb_spi_master_arbiter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_rd_nwr;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic        done_err;
  logic [7:0]  rdata;
  logic        spi_wr_cmd;
  logic        spi_rd_cmd;
  logic [7:0]  mosi_data;
  logic        spi_busy;
  logic [7:0]  miso_data;

  int total  = 0;
  int passed = 0;

  int         m_len  = 4;
  logic [7:0] m_miso = 8'h00;
  bit         m_tie  = 1'b0;

  int busy_rises = 0;
  int both_cnt   = 0;
  int done_cnt   = 0;
  int high_run   = 0;
  int last_high  = 0;
  int low_run    = 0;
  int min_gap    = 1000;
  bit seen_high  = 1'b0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [7:0]  miso;
    int          len;
    bit          tie;
    logic [1:0]  id;
    logic        exp_rd;
    logic [7:0]  mosi;
    logic [7:0]  rdata;
    logic        err;
  } vec_t;

  vec_t tbl [16];

  spi_master_arbiter #(
    .N_REQ(4),
    .MOSI_DATA_WIDTH(8),
    .MISO_DATA_WIDTH(8),
    .BUSY_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_rd_nwr(req_rd_nwr),
    .req_data(req_data),
    .gnt(gnt),
    .done(done),
    .done_id(done_id),
    .done_err(done_err),
    .rdata(rdata),
    .spi_wr_cmd(spi_wr_cmd),
    .spi_rd_cmd(spi_rd_cmd),
    .mosi_data(mosi_data),
    .spi_busy(spi_busy),
    .miso_data(miso_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  // Command-line activity monitor: cmd high/low run lengths and done pulses.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (spi_wr_cmd && spi_rd_cmd) both_cnt <= both_cnt + 1;
    if (spi_wr_cmd || spi_rd_cmd) begin
      if (high_run == 0 && seen_high && low_run < min_gap) min_gap <= low_run;
      high_run  <= high_run + 1;
      low_run   <= 0;
      seen_high <= 1'b1;
    end else begin
      if (high_run > 0) last_high <= high_run;
      high_run <= 0;
      low_run  <= low_run + 1;
    end
  end

  // spi_master model: busy one cycle after a cmd, for m_len cycles, then presents m_miso.
  initial begin
    spi_busy  = 1'b0;
    miso_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && (spi_wr_cmd || spi_rd_cmd) && !m_tie) begin
        spi_busy = 1'b1;
        busy_rises++;
        for (int k = 0; k < m_len; k++) begin
          @(negedge clk);
          if (rst) break;
        end
        spi_busy  = 1'b0;
        miso_data = m_miso;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] rd, input logic [31:0] d,
                              input logic [7:0] mi, input int len, input bit tie,
                              input logic [1:0] id, input logic erd, input logic [7:0] mo,
                              input logic [7:0] rda, input logic er);
    vec_t v;
    v.req = r; v.rd = rd; v.data = d; v.miso = mi; v.len = len; v.tie = tie;
    v.id = id; v.exp_rd = erd; v.mosi = mo; v.rdata = rda; v.err = er;
    return v;
  endfunction

  // Applies one request set at a negedge in IDLE and follows the transaction to the cycle after done.
  task automatic do_txn(input vec_t v, input string tag);
    int n;
    bit seen;
    m_len = v.len; m_miso = v.miso; m_tie = v.tie;
    req = v.req; req_rd_nwr = v.rd; req_data = v.data;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = spi_wr_cmd || spi_rd_cmd;
    end
    chk({tag, " latency"}, n, 2);
    chk({tag, " cmd"}, {spi_rd_cmd, spi_wr_cmd}, v.exp_rd ? 2'b10 : 2'b01);
    chk({tag, " mosi"}, mosi_data, v.mosi);
    chk({tag, " gnt"}, gnt, 4'b0001 << v.id);
    req_data   = ~v.data;
    req_rd_nwr = ~v.rd;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = done;
    end
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " done_id"}, done_id, v.id);
    chk({tag, " done_err"}, done_err, v.err);
    chk({tag, " rdata"}, rdata, v.rdata);
    chk({tag, " mosi_stable"}, mosi_data, v.mosi);
    @(negedge clk);
    chk({tag, " pulse_end"}, {done, gnt}, 5'b0);
    chk({tag, " rdata_hold"}, rdata, v.rdata);
  endtask

  initial begin
    int n;
    int r0;
    int d0;
    bit seen;

    //        req      rd       data          miso  len tie id erd mosi   rdata err
    tbl[0]  = mk(4'b0010, 4'b0000, 32'h0000A500, 8'h00, 20, 0, 0+1, 0, 8'hA5, 8'h00, 0);
    tbl[1]  = mk(4'b0001, 4'b0001, 32'h44332211, 8'h3C,  5, 0, 0,   1, 8'h11, 8'h3C, 0);
    tbl[2]  = mk(4'b1001, 4'b0000, 32'h44332211, 8'h77,  3, 0, 3,   0, 8'h44, 8'h00, 0);
    tbl[3]  = mk(4'b1111, 4'b0101, 32'h44332211, 8'h81,  4, 0, 0,   1, 8'h11, 8'h81, 0);
    tbl[4]  = mk(4'b1111, 4'b0101, 32'h44332211, 8'h82,  4, 0, 1,   0, 8'h22, 8'h00, 0);
    tbl[5]  = mk(4'b1111, 4'b0101, 32'h44332211, 8'h83,  4, 0, 2,   1, 8'h33, 8'h83, 0);
    tbl[6]  = mk(4'b1111, 4'b0101, 32'h44332211, 8'h84,  4, 0, 3,   0, 8'h44, 8'h00, 0);
    tbl[7]  = mk(4'b1111, 4'b0101, 32'h44332211, 8'h85,  4, 0, 0,   1, 8'h11, 8'h85, 0);
    tbl[8]  = mk(4'b1001, 4'b1000, 32'h44332211, 8'h96,  2, 0, 3,   1, 8'h44, 8'h96, 0);
    tbl[9]  = mk(4'b1001, 4'b1000, 32'h44332211, 8'h97,  2, 0, 0,   0, 8'h11, 8'h00, 0);
    tbl[10] = mk(4'b0100, 4'b0000, 32'h44332211, 8'hEE,  4, 1, 2,   0, 8'h33, 8'h00, 1);
    tbl[11] = mk(4'b0100, 4'b0100, 32'h44332211, 8'h5A,  6, 0, 2,   1, 8'h33, 8'h5A, 0);
    tbl[12] = mk(4'b1000, 4'b0000, 32'h44332211, 8'h12,  8, 0, 3,   0, 8'h44, 8'h00, 0);
    tbl[13] = mk(4'b1000, 4'b0000, 32'h44332211, 8'h13,  8, 0, 3,   0, 8'h44, 8'h00, 0);
    tbl[14] = mk(4'b0010, 4'b0000, 32'h44332211, 8'h14,  3, 0, 1,   0, 8'h22, 8'h00, 0);
    tbl[15] = mk(4'b1111, 4'b0000, 32'h44332211, 8'h15,  3, 0, 0,   0, 8'h11, 8'h00, 0);

    rst = 1'b1; req = '0; req_rd_nwr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset gnt", gnt, 0);
    chk("reset done", done, 0);
    chk("reset done_id", done_id, 0);
    chk("reset done_err", done_err, 0);
    chk("reset rdata", rdata, 0);
    chk("reset wr_cmd", spi_wr_cmd, 0);
    chk("reset rd_cmd", spi_rd_cmd, 0);
    chk("reset mosi", mosi_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    do_txn(tbl[10], "timeout");
    chk("timeout cmd_len", last_high, T);
    do_txn(tbl[11], "after_timeout");

    r0 = busy_rises;
    do_txn(tbl[12], "b2b_first");
    do_txn(tbl[13], "b2b_second");
    chk("b2b busy_periods", busy_rises - r0, 2);

    do_txn(tbl[14], "pre_reset");
    m_len = 40; m_miso = 8'hC3; m_tie = 1'b0;
    req = 4'b0100; req_rd_nwr = 4'b0100; req_data = 32'h44332211;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = spi_rd_cmd;
    end
    chk("midreset cmd_seen", seen, 1);
    repeat (4) @(negedge clk);
    chk("midreset gnt_before", gnt, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset cmds", {spi_rd_cmd, spi_wr_cmd}, 0);
    chk("midreset gnt", gnt, 0);
    chk("midreset done", done, 0);
    chk("midreset done_id", done_id, 0);
    chk("midreset mosi", mosi_data, 0);
    @(negedge clk);
    rst = 1'b0; req = '0;
    d0 = done_cnt;
    repeat (50) @(negedge clk);
    chk("midreset no_done", done_cnt - d0, 0);
    do_txn(tbl[15], "post_reset_ptr");
    req = '0;

    chk("never both cmds", both_cnt, 0);
    chk("cmd min gap >= 2", min_gap >= 2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
